conv_sink: RTL and testbench

// - Consumer end of the convolution output stream: takes the 16-bit pxl_out/valid pair from the conv stage.
// - Converts each valid sample to an 8-bit magnitude (|x|, saturated at 255).
// - Writes the magnitudes in raster order into an internal (M-K+1)x(N-K+1) result buffer.
// - Signals frame completion; the buffer is read back through a registered read port (display/UART side).

---
 rtl/conv_sink_if.sv | 8 +
 rtl/conv_sink.sv | 106 ++++++++++
 tb/tb_conv_sink.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/conv_sink_if.sv
// Sample stream from the conv stage into the result sink.
interface conv_sink_if;
    logic [15:0] pxl_in;
    logic        valid_in;

    modport master (output pxl_in, output valid_in);
    modport slave  (input  pxl_in, input  valid_in);
endinterface

// File: rtl/conv_sink.sv
// Conv result sink: |x| (saturated) into a raster buffer with registered readback.
// Define CONV_SINK_THRESH_EN to store binarised (0x00/0xFF) samples instead.
module conv_sink #(
    parameter int N      = 5,
    parameter int M      = 5,
    parameter int K      = 3,
    parameter int ADDR_W = 4,
    parameter int THRESH = 128
) (
    input  logic              clk,
    input  logic              reset,
    conv_sink_if.slave        src,
    output logic [ADDR_W-1:0] out_col,
    output logic [ADDR_W-1:0] out_row,
    output logic              wr_en,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);
    localparam int OC    = N - K + 1;
    localparam int OR    = M - K + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(OC - 1);
    localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(OR - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;
    logic              last;
    logic [7:0]        mem [DEPTH];

    logic [16:0]       sx;
    logic [16:0]       mag;
    logic [7:0]        byte_w;
    logic [ADDR_W-1:0] addr;
    logic              at_end;
    logic              take;

    always_comb begin
        sx     = {src.pxl_in[15], src.pxl_in};
        // 17 bits so that -32768 becomes +32768 without overflow
        mag    = src.pxl_in[15] ? (17'd0 - sx) : sx;
`ifdef CONV_SINK_THRESH_EN
        byte_w = (mag >= 17'(THRESH)) ? 8'hFF : 8'h00;
`else
        byte_w = (mag > 17'd255) ? 8'hFF : mag[7:0];
`endif
        addr   = ADDR_W'(int'(row) * OC + int'(col));
        at_end = (col == COL_MAX) && (row == ROW_MAX);
        take   = src.valid_in && !reset;
    end

    always_ff @(posedge clk) begin
        if (take) mem[addr] <= byte_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            last       <= 1'b0;
            out_col    <= '0;
            out_row    <= '0;
            wr_en      <= 1'b0;
            wr_data    <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 8'h00;
            rd_data    <= 8'h00;
        end else begin
            rd_data    <= mem[rd_addr];
            wr_en      <= src.valid_in;
            frame_done <= 1'b0;
            last       <= 1'b0;
            if (src.valid_in) begin
                wr_data <= byte_w;
                out_col <= col;
                out_row <= row;
                last    <= at_end;
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // last write of the frame became visible last cycle
            if (last) begin
                state      <= DONE;
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
            end else begin
                unique case (state)
                    IDLE:    if (src.valid_in) state <= COLLECT;
                    COLLECT: state <= COLLECT;
                    DONE:    state <= src.valid_in ? COLLECT : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_conv_sink.sv
// Directed self-checking bench for conv_sink.
// Expectations follow CONV_SINK_THRESH_EN when it is defined.
module tb_conv_sink;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] out_col;
    logic [3:0] out_row;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int fd0;

    conv_sink_if bus ();

    conv_sink dut (
        .clk        (clk),
        .reset      (reset),
        .src        (bus),
        .out_col    (out_col),
        .out_row    (out_row),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    function automatic int ex(input int v);
`ifdef CONV_SINK_THRESH_EN
        return (v >= 128) ? 255 : 0;
`else
        return (v > 255) ? 255 : v;
`endif
    endfunction

    task automatic step(input logic v, input logic [15:0] p);
        bus.valid_in = v;
        bus.pxl_in   = p;
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 16'h0000);
        reset = 1'b0;
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.pxl_in   = 16'h0000;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        chk("rst_col", 32'(out_col), 0);
        chk("rst_row", 32'(out_row), 0);
        chk("rst_rd", 32'(rd_data), 0);

        // 1: one full frame of 0..8
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 16'(i));
            chk("t1_wr_en", 32'(wr_en), 1);
            chk("t1_data", 32'(wr_data), 32'(ex(i)));
            chk("t1_row", 32'(out_row), 32'(i / 3));
            chk("t1_col", 32'(out_col), 32'(i % 3));
            chk("t1_nodone", 32'(frame_done), 0);
        end
        step(1'b0, 16'h0000);
        chk("t1_idle_wr", 32'(wr_en), 0);
        chk("t1_done", 32'(frame_done), 1);
        chk("t1_cnt", 32'(frame_cnt), 1);
        step(1'b0, 16'h0000);
        chk("t1_done_pulse", 32'(frame_done), 0);

        // 2: magnitude and saturation
        step(1'b1, 16'hFFF6);
        chk("t2_neg10", 32'(wr_data), 32'(ex(10)));
        step(1'b1, 16'h012C);
        chk("t2_300", 32'(wr_data), 32'(ex(300)));
        step(1'b1, 16'h8000);
        chk("t2_8000", 32'(wr_data), 32'(ex(32768)));
        step(1'b1, 16'h7FFF);
        chk("t2_7fff", 32'(wr_data), 32'(ex(32767)));

        // 3: gap mid-frame, then readback
        do_reset();
        fd0 = fd_cnt;
        for (int i = 0; i < 4; i++) step(1'b1, 16'(i * 20 + 3));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'hFFFF);
            chk("t3_gap_wr", 32'(wr_en), 0);
        end
        chk("t3_hold_row", 32'(out_row), 1);
        chk("t3_hold_col", 32'(out_col), 0);
        for (int i = 4; i < 9; i++) begin
            step(1'b1, 16'(i * 20 + 3));
            chk("t3_row", 32'(out_row), 32'(i / 3));
            chk("t3_col", 32'(out_col), 32'(i % 3));
        end
        step(1'b0, 16'h0000);
        chk("t3_done", 32'(frame_done), 1);
        step(1'b0, 16'h0000);
        chk("t3_one_done", 32'(fd_cnt - fd0), 1);
        for (int a = 0; a < 9; a++) begin
            rd_addr = 4'(a);
            step(1'b0, 16'h0000);
            chk("t3_rd", 32'(rd_data), 32'(ex(a * 20 + 3)));
        end

        // 4: sample during DONE starts the next frame
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 16'(40 + i));
        step(1'b0, 16'h0000);
        chk("t4_done1", 32'(frame_done), 1);
        chk("t4_cnt1", 32'(frame_cnt), 1);
        step(1'b1, 16'h0033);
        chk("t4_wr_en", 32'(wr_en), 1);
        chk("t4_row0", 32'(out_row), 0);
        chk("t4_col0", 32'(out_col), 0);
        chk("t4_data", 32'(wr_data), 32'(ex(51)));
        chk("t4_done_end", 32'(frame_done), 0);
        for (int i = 1; i < 9; i++) step(1'b1, 16'(60 + i));
        chk("t4_last_row", 32'(out_row), 2);
        chk("t4_last_col", 32'(out_col), 2);
        step(1'b0, 16'h0000);
        chk("t4_done2", 32'(frame_done), 1);
        chk("t4_cnt2", 32'(frame_cnt), 2);
        rd_addr = 4'd0;
        step(1'b0, 16'h0000);
        chk("t4_rd0", 32'(rd_data), 32'(ex(51)));

        // 5: reset abandons a partial frame
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 16'(i));
        do_reset();
        chk("t5_rst_row", 32'(out_row), 0);
        chk("t5_rst_col", 32'(out_col), 0);
        chk("t5_rst_cnt", 32'(frame_cnt), 0);
        fd0 = fd_cnt;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 16'(i + 7));
            if (i == 0 || i == 4) begin
                chk("t5_row", 32'(out_row), 32'(i / 3));
                chk("t5_col", 32'(out_col), 32'(i % 3));
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000);
        chk("t5_one_done", 32'(fd_cnt - fd0), 1);
        chk("t5_cnt", 32'(frame_cnt), 1);

        // 6: read-before-write on a colliding address
        do_reset();
        for (int i = 0; i < 9; i++)
            step(1'b1, (i == 4) ? 16'h0011 : 16'h0005);
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0006);
        rd_addr = 4'd4;
        step(1'b1, 16'h0022);
        chk("t6_wr_en", 32'(wr_en), 1);
        chk("t6_old", 32'(rd_data), 32'(ex(17)));
        step(1'b0, 16'h0000);
        chk("t6_new", 32'(rd_data), 32'(ex(34)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
